// File: rtl/sm2_fold_reduce.sv
// SM2 prime-field reducer: folds carry bits above bit 255 back in via 2^256 mod p, then one conditional subtract of p.
// Latency 1..3 cycles (one per fold plus one for correction); one word in flight, in_ready low until output handshake.
// Optional stats counters (fold_cnt, corr_cnt) are built when SM2_FOLD_STATS_EN is defined.
module sm2_fold_reduce #(
    parameter int OVF_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [256+OVF_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [255:0]         out_data,
    output logic                 busy
`ifdef SM2_FOLD_STATS_EN
    ,
    output logic [15:0]          fold_cnt,
    output logic [15:0]          corr_cnt
`endif
);

    localparam int ACC_W = 256 + OVF_W;
    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {IDLE, FOLD, OUT} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [OVF_W-1:0]   hi;
    logic [ACC_W-1:0]   hi_ext, hc, acc_fold;
    logic [256:0]       diff;
    logic               ge_p;
    logic [255:0]       red;
    logic               load, do_fold, finish;

    assign hi     = acc[ACC_W-1:256];
    assign hi_ext = ACC_W'(hi);
    // hi*C with C = 2^224 + 2^96 - 2^64 + 1, shift-add only
    assign hc       = (hi_ext << 224) + (hi_ext << 96) - (hi_ext << 64) + hi_ext;
    assign acc_fold = {{OVF_W{1'b0}}, acc[255:0]} + hc;

    assign diff = {1'b0, acc[255:0]} - {1'b0, P};
    assign ge_p = ~diff[256];
    assign red  = ge_p ? diff[255:0] : acc[255:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        do_fold   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = FOLD;
                end
            end
            FOLD: begin
                busy = 1'b1;
                if (|hi) begin
                    do_fold = 1'b1;
                end else begin
                    finish    = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            out_data <= '0;
        end else begin
            if (load)         acc <= in_data;
            else if (do_fold) acc <= acc_fold;
            if (finish)       out_data <= red;
        end
    end

`ifdef SM2_FOLD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fold_cnt <= '0;
            corr_cnt <= '0;
        end else begin
            if (do_fold && fold_cnt != 16'hFFFF)         fold_cnt <= fold_cnt + 16'd1;
            if (finish && ge_p && corr_cnt != 16'hFFFF)  corr_cnt <= corr_cnt + 16'd1;
        end
    end
`endif

endmodule
